// File: rtl/spi_target_frontend.sv
// SPI target byte engine (mode 0, MSB first): byte 0 is the opcode, later bytes are operands.
// Define SPI_OPERAND_COUNT_EN to add operand_count_out (saturating operand counter).
`timescale 1ns/1ps
module spi_target_frontend #(
    parameter logic [7:0] IDLE_RESPONSE = 8'h00
) (
    input  logic       spi_clock_in,
    input  logic       spi_reset_n_in,
    input  logic       spi_select_n_in,
    input  logic       spi_data_in,
    output logic       spi_data_out,
    output logic [7:0] opcode_out,
    output logic [7:0] operand_out,
    output logic       operand_valid_out,
    input  logic [7:0] response_in,
    output logic       response_read_out
`ifdef SPI_OPERAND_COUNT_EN
    ,
    output logic [7:0] operand_count_out
`endif
);

    typedef enum logic {ST_OPCODE, ST_OPERAND} state_e;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] operand_q, operand_d;
    logic       valid_q, valid_d;
    logic       byte_done_q, byte_done_d;
    logic       desel_q;
    logic [7:0] rx_byte;

    logic [7:0] tx_q, tx_d;
    logic       dout_q, dout_d;
    logic       rd_q, rd_d;

    assign rx_byte = {rx_q, spi_data_in};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        opcode_d    = opcode_q;
        operand_d   = operand_q;
        valid_d     = 1'b0;
        byte_done_d = 1'b0;
        if (spi_select_n_in) begin
            state_d   = ST_OPCODE;
            bit_cnt_d = 3'd0;
        end else begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_done_d = 1'b1;
                if (state_q == ST_OPCODE) begin
                    opcode_d = rx_byte;
                    state_d  = ST_OPERAND;
                end else begin
                    operand_d = rx_byte;
                    valid_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge spi_clock_in or negedge spi_reset_n_in) begin
        if (!spi_reset_n_in) begin
            state_q     <= ST_OPCODE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            opcode_q    <= 8'd0;
            operand_q   <= 8'd0;
            valid_q     <= 1'b0;
            byte_done_q <= 1'b0;
            desel_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            opcode_q    <= opcode_d;
            operand_q   <= operand_d;
            valid_q     <= valid_d;
            byte_done_q <= byte_done_d;
            desel_q     <= spi_select_n_in;
        end
    end

    // Launch side: a completed byte (opcode included) reloads from response_in on the next negedge.
    always_comb begin
        tx_d   = {tx_q[6:0], 1'b0};
        dout_d = tx_q[6];
        rd_d   = 1'b0;
        if (byte_done_q) begin
            tx_d   = response_in;
            dout_d = response_in[7];
            rd_d   = 1'b1;
        end else if (desel_q) begin
            tx_d   = IDLE_RESPONSE;
            dout_d = IDLE_RESPONSE[7];
        end
    end

    always_ff @(negedge spi_clock_in or negedge spi_reset_n_in) begin
        if (!spi_reset_n_in) begin
            tx_q   <= IDLE_RESPONSE;
            dout_q <= IDLE_RESPONSE[7];
            rd_q   <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            dout_q <= dout_d;
            rd_q   <= rd_d;
        end
    end

`ifdef SPI_OPERAND_COUNT_EN
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (spi_select_n_in) begin
            count_d = 8'd0;
        end else if (valid_d && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge spi_clock_in or negedge spi_reset_n_in) begin
        if (!spi_reset_n_in) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign operand_count_out = count_q;
`endif

    assign spi_data_out      = dout_q;
    assign opcode_out        = opcode_q;
    assign operand_out       = operand_q;
    assign operand_valid_out = valid_q;
    assign response_read_out = rd_q;

endmodule
